// File: rtl/rx_pkg.sv
// Shared types for the RX framing controller.
package rx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    LOAD    = 2'd2
  } rx_state_t;

endpackage

// File: rtl/flex_stp_sr.sv
// Parameterized serial-to-parallel shift register, resets to all ones (idle line).
module flex_stp_sr #(
  parameter int NUM_BITS  = 4,
  parameter bit SHIFT_MSB = 1'b1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                shift_enable,
  input  logic                serial_in,
  output logic [NUM_BITS-1:0] parallel_out
);

  logic [NUM_BITS-1:0] nxt;

  generate
    if (SHIFT_MSB) begin : g_msb
      assign nxt = {parallel_out[NUM_BITS-2:0], serial_in};
    end else begin : g_lsb
      // New bits enter at the top, so the first bit received ends up at bit 0.
      assign nxt = {serial_in, parallel_out[NUM_BITS-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)            parallel_out <= '1;
    else if (shift_enable) parallel_out <= nxt;
  end

endmodule

// File: rtl/rx_bit_timer.sv
// Frame cycle timer and bit counter; issues mid-bit shift strobes and the end-of-frame flag.
import rx_pkg::*;

module rx_bit_timer #(
  parameter int CLKS_PER_BIT  = 10,
  parameter int NUM_DATA_BITS = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic shift_strobe,
  output logic frame_done
);

  localparam int TW = $clog2((NUM_DATA_BITS + 2) * CLKS_PER_BIT);
  localparam int BW = $clog2(NUM_DATA_BITS + 2);

  logic [TW-1:0] timer;
  logic [TW-1:0] target;
  logic [BW-1:0] bit_cnt;

  // Strobe i lands mid-way through bit i+1; the start bit gets no strobe.
  assign target       = TW'((int'(bit_cnt) + 1) * CLKS_PER_BIT + CLKS_PER_BIT / 2);
  assign shift_strobe = enable && (timer == target);
  assign frame_done   = shift_strobe && (bit_cnt == BW'(NUM_DATA_BITS));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      timer   <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      timer   <= '0;
      bit_cnt <= '0;
    end else if (enable) begin
      timer <= timer + 1'b1;
      if (shift_strobe) bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// RX framing controller: start detect, strobe sequencing via rx_bit_timer, stop check and byte handoff.
import rx_pkg::*;

module rx_frame_ctrl #(
  parameter int CLKS_PER_BIT  = 10,
  parameter int NUM_DATA_BITS = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     serial_in,
  input  logic [NUM_DATA_BITS:0]   packet_data,
  input  logic                     data_read,
  output logic                     shift_strobe,
  output logic [NUM_DATA_BITS-1:0] rx_data,
  output logic                     data_ready,
  output logic                     overrun_error,
  output logic                     framing_error
);

  // [0],[1] synchronizer, [2] previous synchronized value
  logic [2:0] line_pipe;
  logic       fall;
  logic       start;
  logic       frame_done;
  logic       stop_ok;
  rx_state_t  state, state_nxt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) line_pipe <= 3'b111;
    else        line_pipe <= {line_pipe[1:0], serial_in};
  end

  assign fall    = line_pipe[2] & ~line_pipe[1];
  assign start   = (state == IDLE) && fall;
  assign stop_ok = packet_data[NUM_DATA_BITS];

  rx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .NUM_DATA_BITS(NUM_DATA_BITS)
  ) u_timer (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (start),
    .enable      (state == RECEIVE),
    .shift_strobe(shift_strobe),
    .frame_done  (frame_done)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fall) state_nxt = RECEIVE;
      RECEIVE: if (frame_done) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data       <= '0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (start) framing_error <= 1'b0;
      if (state == LOAD && stop_ok) begin
        // A read in the load cycle acknowledges the old byte, so no overrun.
        rx_data       <= packet_data[NUM_DATA_BITS-1:0];
        data_ready    <= 1'b1;
        overrun_error <= data_ready & ~data_read;
      end else begin
        if (state == LOAD) framing_error <= 1'b1;
        if (data_read) begin
          data_ready    <= 1'b0;
          overrun_error <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Closed-loop bench: rx_frame_ctrl driving flex_stp_sr, checked against a frame-level model.
import rx_pkg::*;

module tb_rx_frame_ctrl;

  localparam int C = 10;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         serial_in = 1'b1;
  logic         data_read = 1'b0;
  logic         shift_strobe;
  logic [N:0]   packet_data;
  logic [N-1:0] rx_data;
  logic         data_ready, overrun_error, framing_error;

  int tests = 0;
  int fails = 0;

  // Frame-level model of the consumer-visible outputs
  logic [7:0] m_data = 8'h00;
  logic       m_ready = 1'b0;
  logic       m_ovr = 1'b0;
  logic       m_fe = 1'b0;

  always #5 clk = ~clk;

  rx_frame_ctrl #(.CLKS_PER_BIT(C), .NUM_DATA_BITS(N)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .serial_in    (serial_in),
    .packet_data  (packet_data),
    .data_read    (data_read),
    .shift_strobe (shift_strobe),
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .overrun_error(overrun_error),
    .framing_error(framing_error)
  );

  flex_stp_sr #(.NUM_BITS(N + 1), .SHIFT_MSB(1'b0)) u_sr (
    .clk         (clk),
    .n_rst       (n_rst),
    .shift_enable(shift_strobe),
    .serial_in   (serial_in),
    .parallel_out(packet_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, " rx_data"}, 32'(rx_data), 32'(m_data));
    chk({tag, " data_ready"}, 32'(data_ready), 32'(m_ready));
    chk({tag, " overrun"}, 32'(overrun_error), 32'(m_ovr));
    chk({tag, " framing"}, 32'(framing_error), 32'(m_fe));
  endtask

  // Strobes fall at t = (i+1)*C + C/2 for i = 0..N, t counted from the first RECEIVE cycle
  function automatic logic exp_strobe(input int t);
    if (t < C + C / 2 || t > (N + 1) * C + C / 2) return 1'b0;
    return ((t - C / 2) % C) == 0;
  endfunction

  // Called at a negedge; line changes land on negedges, so RECEIVE t = k - 3.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic rd,
                            input int glitch, input logic tail, input int abort_at);
    logic [9:0] bits;
    int         ns;
    bits = {stop, d, 1'b0};
    ns   = 0;
    m_fe = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (k == abort_at) return;
      chk($sformatf("strobe k=%0d", k), 32'(shift_strobe), 32'(exp_strobe(k - 3)));
      if (shift_strobe) ns++;
      if (k == 50 || k == 99) chk_outs($sformatf("mid-frame k=%0d", k));
      serial_in = (k == glitch) ? 1'b0 : bits[k / 10];
      data_read = rd && (k == 99);
      @(negedge clk);
    end
    serial_in = tail;
    data_read = 1'b0;
    if (stop) begin
      m_ovr   = m_ready && !rd;
      m_ready = 1'b1;
      m_data  = d;
    end else begin
      m_fe = 1'b1;
      if (rd) begin
        m_ready = 1'b0;
        m_ovr   = 1'b0;
      end
    end
    chk("strobe count", 32'(ns), 32'(N + 1));
    chk_outs($sformatf("frame %02h stop=%0d", d, stop));
  endtask

  task automatic pulse_read();
    data_read = 1'b1;
    @(negedge clk);
    data_read = 1'b0;
    m_ready = 1'b0;
    m_ovr   = 1'b0;
    chk_outs("after read");
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk({tag, " strobe"}, 32'(shift_strobe), 32'(0));
      @(negedge clk);
    end
    chk_outs(tag);
  endtask

  initial begin
    logic [7:0] d;
    logic       st, rd;

    repeat (3) @(negedge clk);
    chk_outs("reset");
    chk("reset strobe", 32'(shift_strobe), 32'(0));
    n_rst = 1'b1;
    @(negedge clk);

    // Reset mid-frame at t = 40
    send_frame(8'hA5, 1'b1, 1'b0, -1, 1'b1, 43);
    n_rst = 1'b0;
    serial_in = 1'b1;
    #1;
    m_data = 8'h00; m_ready = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
    chk_outs("abort");
    chk("abort strobe", 32'(shift_strobe), 32'(0));
    chk("abort state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    n_rst = 1'b1;
    idle(120, "post-abort");
    chk("post-abort state", 32'(dut.state), 32'(IDLE));

    // Good frame
    send_frame(8'hA5, 1'b1, 1'b0, -1, 1'b1, -1);
    idle(5, "after A5");
    pulse_read();

    // Framing error
    send_frame(8'h3C, 1'b0, 1'b0, -1, 1'b1, -1);
    idle(5, "after 3C");

    // Overrun: back-to-back, no read
    send_frame(8'h11, 1'b1, 1'b0, -1, 1'b1, -1);
    send_frame(8'h22, 1'b1, 1'b0, -1, 1'b1, -1);
    idle(3, "overrun");
    pulse_read();
    idle(3, "overrun cleared");

    // Read collides with load
    send_frame(8'h55, 1'b1, 1'b0, -1, 1'b1, -1);
    send_frame(8'h7E, 1'b1, 1'b1, -1, 1'b1, -1);
    idle(3, "collide");
    pulse_read();

    // One-cycle low glitch inside a high data bit
    d = 8'($urandom()) | 8'h04;
    send_frame(d, 1'b1, 1'b0, 33, 1'b1, -1);
    idle(3, "glitch");

    // Break: line stays low through and after the stop bit
    send_frame(8'h00, 1'b0, 1'b0, -1, 1'b0, -1);
    idle(150, "break");
    serial_in = 1'b1;
    idle(20, "break released");
    d = 8'($urandom());
    send_frame(d, 1'b1, 1'b1, -1, 1'b1, -1);
    idle(3, "after break");

    // Random frames
    for (int f = 0; f < 8; f++) begin
      d  = 8'($urandom());
      st = ($urandom_range(0, 3) != 0);
      rd = st && ($urandom_range(0, 1) == 1);
      send_frame(d, st, rd, -1, 1'b1, -1);
      if ($urandom_range(0, 2) == 0) pulse_read();
      else idle($urandom_range(0, 6), "random gap");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
